// File: rtl/nn_bram_pkg.sv
// nn_bram_pkg: constants and FSM encoding shared by the BRAM row loader and row fetcher
package nn_bram_pkg;
    localparam int ROW_LEN     = 28;
    localparam int BRAM_AW     = 11;
    localparam int BRAM_DW     = 8;
    localparam int BRAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift of {valid, index} that tags each BRAM read until its data returns
module rd_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [IW-1:0] idx_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    logic [DEPTH-1:0] valid_q;
    logic [IW-1:0]    idx_q [DEPTH];

    // shift tags one stage per cycle; reset drops every read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];
endmodule

// File: rtl/bram_row_fetch.sv
// bram_row_fetch: reads an N-byte row from BRAM and presents it as a double-buffered parallel bus
module bram_row_fetch
    import nn_bram_pkg::*;
#(
    parameter int N      = ROW_LEN,
    parameter int AW     = BRAM_AW,
    parameter int DW     = BRAM_DW,
    parameter int RD_LAT = BRAM_RD_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   ADDR_BASE,
    output logic            BRAM_EN,
    output logic [AW-1:0]   BRAM_ADDR,
    input  logic [DW-1:0]   BRAM_DO,
    output logic            busy,
    output logic            done,
    output logic            row_valid,
    output logic [N*DW-1:0] ROW_OUT
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [IW-1:0] LAST_DRAIN = IW'(RD_LAT - 1);

    fetch_state_e    state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic [N*DW-1:0] shadow_q, row_q;
    logic            done_q, valid_q;
    logic            tag_valid;
    logic [IW-1:0]   tag_idx;
    logic            commit;

    // state, counter and latched base address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // cnt is the byte index in ISSUE and the drain cycle count in DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                cnt_d   = '0;
                base_d  = ADDR_BASE;
            end
            ISSUE: begin
                state_d = (cnt_q == LAST_IDX) ? DRAIN : ISSUE;
                cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
            DRAIN: begin
                state_d = (cnt_q == LAST_DRAIN) ? IDLE : DRAIN;
                cnt_d   = (cnt_q == LAST_DRAIN) ? '0 : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // BRAM port and busy come straight from state; address wraps modulo 2^AW
    always_comb begin
        BRAM_EN   = (state_q == ISSUE);
        BRAM_ADDR = BRAM_EN ? base_q + AW'(cnt_q) : '0;
        busy      = (state_q != IDLE);
    end

    rd_tag_pipe #(
        .DEPTH(RD_LAT),
        .IW   (IW)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .valid_i(BRAM_EN),
        .idx_i  (cnt_q),
        .valid_o(tag_valid),
        .idx_o  (tag_idx)
    );

    assign commit = tag_valid && (tag_idx == LAST_IDX);

    // fill the shadow buffer; on the last byte copy it (with that byte) to the output row at once
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (tag_valid) shadow_q[tag_idx*DW +: DW] <= BRAM_DO;
            if (commit) row_q <= {BRAM_DO, shadow_q[(N-1)*DW-1:0]};
            done_q  <= commit;
            valid_q <= valid_q | commit;
        end
    end

    assign done      = done_q;
    assign row_valid = valid_q;
    assign ROW_OUT   = row_q;
endmodule
